booth_mult_ctrl: RTL and testbench

//  Sequencer for the radix-4 Booth datapath. Accepts one operand pair per

---
 rtl/booth_mult_ctrl_pkg.sv | 10 +
 rtl/booth_mult_ctrl_if.sv | 22 ++
 rtl/booth_datapath.sv | 67 ++++++
 rtl/booth_mult_ctrl_step_cnt.sv | 24 ++
 rtl/booth_mult_ctrl.sv | 97 +++++++++
 tb/tb_booth_mult_ctrl.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/booth_mult_ctrl_pkg.sv
// booth_pkg: shared state encoding and step-count helper for the Booth multiplier controller.
package booth_pkg;

   typedef enum logic [1:0] {IDLE, RUN, CAPT, DONE} booth_state_e;

   function automatic int booth_steps(input int dw);
      return dw / 2;
   endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// booth_mult_ctrl_if: operand request and product response handshakes of the Booth controller.
interface booth_mult_ctrl_if #(parameter int DW = 16);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] m_in;
   logic [DW-1:0] q_in;
   logic          out_valid;
   logic          out_ready;
   logic [2*DW-1:0] out_product;

   modport slave (
      input  in_valid, m_in, q_in, out_ready,
      output in_ready, out_valid, out_product
   );

   modport master (
      output in_valid, m_in, q_in, out_ready,
      input  in_ready, out_valid, out_product
   );

endinterface

// File: rtl/booth_datapath.sv
// booth_datapath: {A,Q,q-1} shift register multiplier; op_sel picks a radix-4 (two-bit) or radix-2 step.
module booth_datapath #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic                      shift,
   input  logic                      op_sel,
   input  logic [DATA_WIDTH-1:0]     m_in,
   input  logic [DATA_WIDTH-1:0]     q_in,
   output logic [2*DATA_WIDTH-1:0]   product
);

   localparam int DW = DATA_WIDTH;
   localparam int W  = DW + 2;

   logic [DW-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
   logic          qm1_q, qm1_d;
   logic signed [W-1:0] m_x, a_x, pp4, pp2, acc;
   logic [2:0]    b4;
   logic [1:0]    b2;

   // A only needs DW bits between steps; the two guard bits absorb +/-2M during the add.
   always_comb begin
      m_x = {{2{m_q[DW-1]}}, m_q};
      a_x = {{2{a_q[DW-1]}}, a_q};
      b4  = {q_q[1:0], qm1_q};
      b2  = {q_q[0], qm1_q};
      pp4 = (b4 == 3'b001 || b4 == 3'b010) ? m_x :
            (b4 == 3'b011) ? m_x <<< 1 :
            (b4 == 3'b100) ? -(m_x <<< 1) :
            (b4 == 3'b101 || b4 == 3'b110) ? -m_x : '0;
      pp2 = (b2 == 2'b01) ? m_x : (b2 == 2'b10) ? -m_x : '0;
      acc = a_x + (op_sel ? pp4 : pp2);
      a_d   = a_q;
      q_d   = q_q;
      qm1_d = qm1_q;
      m_d   = m_q;
      if (load) begin
         a_d   = '0;
         q_d   = q_in;
         qm1_d = 1'b0;
         m_d   = m_in;
      end else if (shift) begin
         a_d   = op_sel ? acc[W-1:2] : acc[W-2:1];
         q_d   = op_sel ? {acc[1:0], q_q[DW-1:2]} : {acc[0], q_q[DW-1:1]};
         qm1_d = op_sel ? q_q[1] : q_q[0];
      end
   end

   assign product = {a_q, q_q};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_q   <= '0;
         q_q   <= '0;
         qm1_q <= 1'b0;
         m_q   <= '0;
      end else begin
         a_q   <= a_d;
         q_q   <= q_d;
         qm1_q <= qm1_d;
         m_q   <= m_d;
      end

endmodule

// File: rtl/booth_mult_ctrl_step_cnt.sv
// booth_step_cnt: clearable up-counter of radix-4 steps with terminal-count flag.
module booth_step_cnt #(
   parameter int STEPS = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int SW = $clog2(STEPS + 1);

   logic [SW-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr ? '0 : en ? cnt_q + SW'(1) : cnt_q;

   assign tc = cnt_q == SW'(STEPS - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;

endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequences one radix-4 Booth multiply per handshake and holds the product
// until the consumer takes it.
module booth_mult_ctrl
   import booth_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   booth_mult_ctrl_if.slave        bus,
   input  logic                    flush,
   output logic                    dp_load,
   output logic                    dp_shift,
   output logic                    dp_op_sel,
   output logic [DATA_WIDTH-1:0]   dp_m,
   output logic [DATA_WIDTH-1:0]   dp_q,
   input  logic [2*DATA_WIDTH-1:0] dp_product,
   output logic                    busy,
   output logic [CNT_WIDTH-1:0]    op_count
);

   localparam int STEPS = booth_steps(DATA_WIDTH);

   if (DATA_WIDTH % 2 != 0 || DATA_WIDTH < 4) begin : g_bad_width
      $error("booth_mult_ctrl: DATA_WIDTH must be even and >= 4");
   end

   booth_state_e              state_q, state_d;
   logic                      out_valid_q, out_valid_d;
   logic [2*DATA_WIDTH-1:0]   out_product_q, out_product_d;
   logic [CNT_WIDTH-1:0]      op_count_q, op_count_d;
   logic                      accept, cnt_clr, step_tc;

   booth_step_cnt #(.STEPS(STEPS)) u_step_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (dp_shift),
      .tc    (step_tc)
   );

   // flush overrides everything, including a coincident accept.
   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q;
      out_product_d = out_product_q;
      op_count_d    = op_count_q;
      bus.in_ready  = state_q == IDLE && !flush;
      accept        = bus.in_ready && bus.in_valid;
      dp_load       = accept;
      dp_shift      = state_q == RUN && !flush;
      dp_op_sel     = dp_shift;
      dp_m          = accept ? bus.m_in : '0;
      dp_q          = accept ? bus.q_in : '0;
      cnt_clr       = flush || accept;
      if (flush) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = accept ? RUN : IDLE;
            RUN:  state_d = step_tc ? CAPT : RUN;
            CAPT: begin
               out_product_d = dp_product;
               out_valid_d   = 1'b1;
               state_d       = DONE;
            end
            DONE: if (bus.out_ready) begin
               out_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_WIDTH'(1);
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_product = out_product_q;
   assign busy            = state_q != IDLE;
   assign op_count        = op_count_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q       <= IDLE;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         op_count_q    <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_product_q <= out_product_d;
         op_count_q    <= op_count_d;
      end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: directed vectors for the Booth controller wired to a booth_datapath.
module tb_booth_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        dp_load, dp_shift, dp_op_sel, busy;
   logic [15:0] dp_m, dp_q, op_count;
   logic [31:0] dp_product;
   int          total = 0;
   int          bad = 0;
   int          exp_cnt = 0;
   int          lat, nld, nsh, seen;
   logic        rdy;
   logic [31:0] prod;

   booth_mult_ctrl_if #(.DW(16)) bus ();

   always #5 clk = ~clk;

   booth_mult_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .flush      (flush),
      .dp_load    (dp_load),
      .dp_shift   (dp_shift),
      .dp_op_sel  (dp_op_sel),
      .dp_m       (dp_m),
      .dp_q       (dp_q),
      .dp_product (dp_product),
      .busy       (busy),
      .op_count   (op_count)
   );

   booth_datapath #(.DATA_WIDTH(16)) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (dp_load),
      .shift   (dp_shift),
      .op_sel  (dp_op_sel),
      .m_in    (dp_m),
      .q_in    (dp_q),
      .product (dp_product)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called #1 after a posedge; returns on the negedge where out_valid is first seen.
   task automatic run(input logic [15:0] m, input logic [15:0] q, output int l, output int nl,
                      output int ns, output logic r, output logic [31:0] p);
      bus.in_valid = 1'b1;
      bus.m_in = m;
      bus.q_in = q;
      @(negedge clk);
      r = bus.in_ready;
      nl = int'(dp_load);
      ns = int'(dp_shift);
      l = 0;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      while (bus.out_valid !== 1'b1 && l < 40) begin
         @(negedge clk);
         l++;
         nl += int'(dp_load);
         ns += int'(dp_shift);
      end
      p = bus.out_product;
   endtask

   task automatic ack;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.m_in = '0;
      bus.q_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {dp_load, dp_shift, dp_op_sel}, 0);
      chk("rst_op_count", op_count, 0);
      rst_n = 1'b1;

      @(posedge clk);
      #1 run(16'd3, 16'd5, lat, nld, nsh, rdy, prod);
      chk("p3x5", prod, 32'h0000_000F);
      chk("lat3x5", lat, 10);
      chk("load3x5", nld, 1);
      chk("shift3x5", nsh, 8);
      chk("rdy3x5", rdy, 1);
      ack();
      exp_cnt = 1;
      chk("cnt1", op_count, exp_cnt);
      chk("ov_clear1", bus.out_valid, 0);

      @(posedge clk);
      #1 run(16'hFFF9, 16'd6, lat, nld, nsh, rdy, prod);
      chk("pm7x6", prod, 32'hFFFF_FFD6);
      bus.in_valid = 1'b1;
      bus.m_in = 16'd5;
      bus.q_in = 16'd5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_prod", bus.out_product, 32'hFFFF_FFD6);
         chk("hold_in_ready", bus.in_ready, 0);
         chk("hold_load", dp_load, 0);
      end
      bus.in_valid = 1'b0;
      ack();
      exp_cnt = 2;
      chk("cnt2", op_count, exp_cnt);

      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 run(16'd2, 16'd4, lat, nld, nsh, rdy, prod);
      chk("p2x4", prod, 32'd8);
      @(posedge clk);
      #1 run(16'hFFFD, 16'hFFFD, lat, nld, nsh, rdy, prod);
      chk("b2b_ready", rdy, 1);
      chk("b2b_load", nld, 1);
      chk("pm3xm3", prod, 32'd9);
      chk("lat_b2b", lat, 10);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      exp_cnt = 4;
      chk("cnt4", op_count, exp_cnt);

      @(posedge clk);
      #1 bus.in_valid = 1'b1;
      bus.m_in = 16'd7;
      bus.q_in = 16'd7;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_shift", dp_shift, 0);
      chk("flush_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_idle", busy, 0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      chk("flush_no_valid", seen, 0);
      chk("flush_cnt", op_count, exp_cnt);
      @(posedge clk);
      #1 flush = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("flush_idle_load", dp_load, 0);
      chk("flush_idle_rdy", bus.in_ready, 0);
      @(posedge clk);
      #1 flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_no_accept", busy, 0);
      @(posedge clk);
      #1 run(16'd10, 16'd10, lat, nld, nsh, rdy, prod);
      chk("p10x10", prod, 32'd100);
      chk("lat10x10", lat, 10);
      ack();
      exp_cnt = 5;
      chk("cnt5", op_count, exp_cnt);

      @(posedge clk);
      #1 bus.in_valid = 1'b1;
      bus.m_in = 16'd9;
      bus.q_in = 16'd9;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      chk("arst_shift", dp_shift, 0);
      chk("arst_cnt", op_count, 0);
      chk("arst_prod", bus.out_product, 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      @(posedge clk);
      #1 run(16'd1, 16'hFFFF, lat, nld, nsh, rdy, prod);
      chk("p1xm1", prod, 32'hFFFF_FFFF);
      chk("lat1xm1", lat, 10);
      ack();
      exp_cnt = 1;
      chk("cnt_after_rst", op_count, exp_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
